// File: rtl/pht_ctrl_if.sv
// ---------------------------------------------------------------------------
// pht_ctrl_if
// Bundles every handshake and PHT-side signal of pht_ctrl.
//   slave  : the controller side (pht_ctrl)
//   master : the environment side (requesters, resolver and the PHT)
// Signal groups:
//   prediction request  : pred_req, pc_idx, pred_ack
//   prediction response : pred_out, pred_out_idx, pred_out_valid, pred_timeout
//   resolve enqueue     : res_req, res_idx, res_taken, res_ready
//   PHT access          : pht_predict, pht_resolve, pht_incr, pht_decr,
//                         pht_index, pht_pred, pht_pred_valid
//   history             : ghr
// ---------------------------------------------------------------------------
interface pht_ctrl_if #(
  parameter int W_IND = 4
);
  logic             pred_req;
  logic [W_IND-1:0] pc_idx;
  logic             pred_ack;

  logic             pred_out;
  logic [W_IND-1:0] pred_out_idx;
  logic             pred_out_valid;
  logic             pred_timeout;

  logic             res_req;
  logic [W_IND-1:0] res_idx;
  logic             res_taken;
  logic             res_ready;

  logic             pht_predict;
  logic             pht_resolve;
  logic             pht_incr;
  logic             pht_decr;
  logic [W_IND-1:0] pht_index;
  logic             pht_pred;
  logic             pht_pred_valid;

  logic [W_IND-1:0] ghr;

  modport slave (
    input  pred_req, pc_idx, res_req, res_idx, res_taken, pht_pred, pht_pred_valid,
    output pred_ack, pred_out, pred_out_idx, pred_out_valid, pred_timeout,
           res_ready, pht_predict, pht_resolve, pht_incr, pht_decr, pht_index, ghr
  );

  modport master (
    output pred_req, pc_idx, res_req, res_idx, res_taken, pht_pred, pht_pred_valid,
    input  pred_ack, pred_out, pred_out_idx, pred_out_valid, pred_timeout,
           res_ready, pht_predict, pht_resolve, pht_incr, pht_decr, pht_index, ghr
  );
endinterface

// File: rtl/pht_ctrl.sv
// ---------------------------------------------------------------------------
// pht_ctrl
// Arbitrates a pattern history table between branch prediction lookups and
// branch resolution updates. Resolutions are buffered in a small queue and
// drained one per cycle; predictions use a gshare index (pc_idx XOR ghr) and
// wait for the PHT to answer, with a bounded timeout.
// Ports:
//   clk : clock, all state changes on its rising edge
//   rst : asynchronous active-low reset
//   bus : pht_ctrl_if.slave, carrying request/response/resolve/PHT signals
// Parameters:
//   W_IND      : PHT index width (PHT depth 2**W_IND), at least 2
//   FIFO_DEPTH : resolve-queue entries
//   TIMEOUT    : WAIT_PRED cycles allowed before a timeout response
// ---------------------------------------------------------------------------
module pht_ctrl #(
  parameter int W_IND      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4
) (
  input  logic      clk,
  input  logic      rst,
  pht_ctrl_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_PRED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // queue entry = {index, taken}
  logic [W_IND:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [W_IND-1:0] r_ghr;
  logic [W_IND-1:0] r_idx;
  logic [TMO_W-1:0] r_tmo;

  logic             r_pred_out;
  logic [W_IND-1:0] r_pred_out_idx;
  logic             r_pred_out_valid;
  logic             r_pred_timeout;

  logic             w_full;
  logic             w_empty;
  logic             w_enq;
  logic             w_drain;
  logic             w_pred_ack;
  logic             w_hit;
  logic             w_expire;
  logic [W_IND-1:0] w_head_idx;
  logic             w_head_taken;
  logic             w_pht_predict;
  logic             w_pht_resolve;
  logic             w_pht_incr;
  logic             w_pht_decr;
  logic [W_IND-1:0] w_pht_index;

  // Pointer advance with explicit wrap so non power-of-two depths still work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  assign w_full       = (r_count == CNT_FULL);
  assign w_empty      = (r_count == {CNT_W{1'b0}});
  assign w_enq        = bus.res_req & ~w_full;
  assign w_head_idx   = r_mem[r_rd_ptr][W_IND:1];
  assign w_head_taken = r_mem[r_rd_ptr][0];

  // Next-state and access arbitration: full queue beats prediction, which
  // beats an opportunistic drain; WAIT_PRED blocks drains entirely.
  always_comb begin
    w_state_nxt = r_state;
    w_drain     = 1'b0;
    w_pred_ack  = 1'b0;
    w_hit       = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_full) begin
          w_drain = 1'b1;
        end else if (bus.pred_req) begin
          w_pred_ack  = 1'b1;
          w_state_nxt = WAIT_PRED;
        end else if (!w_empty) begin
          w_drain = 1'b1;
        end else begin
          w_drain = 1'b0;
        end
      end
      WAIT_PRED: begin
        // A response arriving on the last allowed cycle still wins.
        if (bus.pht_pred_valid) begin
          w_hit       = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_tmo == TMO_LAST) begin
          w_expire    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT_PRED;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // PHT strobes; predict and resolve are mutually exclusive by state.
  always_comb begin
    w_pht_predict = (r_state == WAIT_PRED);
    w_pht_resolve = w_drain;
    w_pht_incr    = w_drain & w_head_taken;
    w_pht_decr    = w_drain & ~w_head_taken;
    if (r_state == WAIT_PRED) begin
      w_pht_index = r_idx;
    end else if (w_drain) begin
      w_pht_index = w_head_idx;
    end else begin
      w_pht_index = {W_IND{1'b0}};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Resolve queue storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= {(W_IND + 1){1'b0}};
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_enq) begin
        r_mem[r_wr_ptr] <= {bus.res_idx, bus.res_taken};
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_drain) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Global history shifts in the outcome of every drained branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ghr <= {W_IND{1'b0}};
    end else if (w_drain) begin
      r_ghr <= {r_ghr[W_IND-2:0], w_head_taken};
    end else begin
      r_ghr <= r_ghr;
    end
  end

  // Latch the gshare index on accept and count cycles spent waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= {W_IND{1'b0}};
      r_tmo <= {TMO_W{1'b0}};
    end else begin
      if (w_pred_ack) begin
        r_idx <= bus.pc_idx ^ r_ghr;
      end
      if ((r_state == WAIT_PRED) && (w_state_nxt == WAIT_PRED)) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end else begin
        r_tmo <= {TMO_W{1'b0}};
      end
    end
  end

  // Registered prediction response; valid and timeout are one-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pred_out       <= 1'b0;
      r_pred_out_idx   <= {W_IND{1'b0}};
      r_pred_out_valid <= 1'b0;
      r_pred_timeout   <= 1'b0;
    end else begin
      r_pred_out_valid <= w_hit | w_expire;
      r_pred_timeout   <= w_expire;
      r_pred_out       <= w_hit & bus.pht_pred;
      if (w_hit | w_expire) begin
        r_pred_out_idx <= r_idx;
      end
    end
  end

  assign bus.pred_ack       = w_pred_ack;
  assign bus.res_ready      = ~w_full;
  assign bus.pht_predict    = w_pht_predict;
  assign bus.pht_resolve    = w_pht_resolve;
  assign bus.pht_incr       = w_pht_incr;
  assign bus.pht_decr       = w_pht_decr;
  assign bus.pht_index      = w_pht_index;
  assign bus.ghr            = r_ghr;
  assign bus.pred_out       = r_pred_out;
  assign bus.pred_out_idx   = r_pred_out_idx;
  assign bus.pred_out_valid = r_pred_out_valid;
  assign bus.pred_timeout   = r_pred_timeout;

endmodule

// File: tb/tb_pht_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pht_ctrl
// Drives pht_ctrl through directed scenarios and random traffic. Expected PHT
// drains, request accepts and prediction responses are queued by a
// transaction-level model and matched by a monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_pht_ctrl;
  localparam int W = 4;
  localparam int D = 4;
  localparam int T = 4;

  logic clk;
  logic rst;

  pht_ctrl_if #(.W_IND(W)) bus ();

  pht_ctrl #(.W_IND(W), .FIFO_DEPTH(D), .TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] idx;
    logic         b;
    logic         tmo;
  } ev_t;

  ev_t q_drain[$];
  ev_t q_ack[$];
  ev_t q_res[$];
  ev_t mon_e;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int exp_cyc = -1;
  logic         exp_ready;
  logic [W-1:0] exp_ghr;
  logic [W-1:0] cur_idx = '0;

  // reference model state
  logic [W:0]   m_fifo[$];
  int           m_ghr;
  bit           m_wait;
  logic [W-1:0] m_widx;
  int           m_wcnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic miss(input string name, input int want);
    n_chk++;
    $display("FAIL %s: event expected at cycle %0d not seen (now %0d)", name, want, cyc);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    q_drain.delete();
    q_ack.delete();
    q_res.delete();
    m_ghr  = 0;
    m_wait = 1'b0;
    m_wcnt = 0;
  endtask

  // One cycle of the behavioural model.
  task automatic model_cycle(input bit preq, input logic [W-1:0] pc, input bit rreq,
                             input logic [W-1:0] ridx, input bit rt, input bit pv, input bit pp);
    bit         full;
    logic [W:0] head;
    full      = (m_fifo.size() == D);
    exp_ready = !full;
    exp_ghr   = W'(m_ghr);
    if (!m_wait) begin
      if (full || (!preq && m_fifo.size() > 0)) begin
        head = m_fifo.pop_front();
        q_drain.push_back('{cyc, head[W:1], head[0], 1'b0});
        m_ghr = (m_ghr * 2 + int'(head[0])) % (1 << W);
      end else if (preq) begin
        m_widx = pc ^ W'(m_ghr);
        q_ack.push_back('{cyc, m_widx, 1'b0, 1'b0});
        m_wait = 1'b1;
        m_wcnt = 0;
      end
    end else begin
      m_wcnt++;
      if (pv) begin
        q_res.push_back('{cyc + 1, m_widx, pp, 1'b0});
        m_wait = 1'b0;
      end else if (m_wcnt == T) begin
        q_res.push_back('{cyc + 1, m_widx, 1'b0, 1'b1});
        m_wait = 1'b0;
      end
    end
    if (rreq && !full) m_fifo.push_back({ridx, rt});
  endtask

  // Drive one cycle of inputs just after the rising edge; return at the
  // falling edge so the caller can inspect that cycle's outputs.
  task automatic step(input bit preq, input logic [W-1:0] pc, input bit rreq,
                      input logic [W-1:0] ridx, input bit rt, input bit pv, input bit pp);
    @(posedge clk);
    #1;
    bus.pred_req       = preq;
    bus.pc_idx         = pc;
    bus.res_req        = rreq;
    bus.res_idx        = ridx;
    bus.res_taken      = rt;
    bus.pht_pred_valid = pv;
    bus.pht_pred       = pp;
    model_cycle(preq, pc, rreq, ridx, rt, pv, pp);
    exp_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pops the expectation matching each DUT event.
  always @(negedge clk) begin
    if (rst === 1'b1 && exp_cyc == cyc) begin
      chk("res_ready", 32'(bus.res_ready), 32'(exp_ready));
      chk("ghr", 32'(bus.ghr), 32'(exp_ghr));
      if (bus.pht_predict && bus.pht_resolve) chk("predict_and_resolve", 32'd1, 32'd0);
      if ((bus.pht_incr || bus.pht_decr) && !bus.pht_resolve) chk("incr_decr_no_resolve", 32'd1, 32'd0);
      if (bus.pred_timeout && !bus.pred_out_valid) chk("timeout_without_valid", 32'd1, 32'd0);

      if (bus.pht_resolve) begin
        if (q_drain.size() == 0) chk("drain_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = q_drain.pop_front();
          chk("drain_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("drain_index", 32'(bus.pht_index), 32'(mon_e.idx));
          chk("drain_incr", 32'(bus.pht_incr), 32'(mon_e.b));
          chk("drain_decr", 32'(bus.pht_decr), 32'(!mon_e.b));
        end
      end
      if (bus.pred_ack) begin
        if (q_ack.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = q_ack.pop_front();
          chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
          cur_idx = mon_e.idx;
        end
      end
      if (bus.pht_predict) chk("predict_index", 32'(bus.pht_index), 32'(cur_idx));
      if (bus.pred_out_valid) begin
        if (q_res.size() == 0) chk("result_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = q_res.pop_front();
          chk("result_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("result_out", 32'(bus.pred_out), 32'(mon_e.b));
          chk("result_idx", 32'(bus.pred_out_idx), 32'(mon_e.idx));
          chk("result_timeout", 32'(bus.pred_timeout), 32'(mon_e.tmo));
        end
      end
      while (q_drain.size() > 0 && q_drain[0].cyc < cyc) begin miss("drain", q_drain[0].cyc); void'(q_drain.pop_front()); end
      while (q_ack.size() > 0 && q_ack[0].cyc < cyc) begin miss("ack", q_ack[0].cyc); void'(q_ack.pop_front()); end
      while (q_res.size() > 0 && q_res[0].cyc < cyc) begin miss("result", q_res[0].cyc); void'(q_res.pop_front()); end
    end
  end

  initial begin
    rst = 1'b0;
    bus.pred_req = 1'b0; bus.pc_idx = '0; bus.res_req = 1'b0; bus.res_idx = '0;
    bus.res_taken = 1'b0; bus.pht_pred_valid = 1'b0; bus.pht_pred = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res_ready", 32'(bus.res_ready), 32'd1);
    chk("rst_ghr", 32'(bus.ghr), 32'd0);
    chk("rst_out_valid", 32'(bus.pred_out_valid), 32'd0);
    chk("rst_strobes", 32'({bus.pht_predict, bus.pht_resolve, bus.pht_incr, bus.pht_decr}), 32'd0);
    rst = 1'b1;

    // basic prediction, PHT answers on the first wait cycle
    step(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("s1_ack", 32'(bus.pred_ack), 32'd1);
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    chk("s1_predict", 32'(bus.pht_predict), 32'd1);
    chk("s1_index", 32'(bus.pht_index), 32'd5);
    idle();
    chk("s1_out", 32'({bus.pred_out_valid, bus.pred_out, bus.pred_out_idx}), 32'({1'b1, 1'b1, 4'd5}));
    idle();
    chk("s1_single_pulse", 32'(bus.pred_out_valid), 32'd0);

    // single resolve (12, not taken)
    step(1'b0, 4'd0, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    idle();
    chk("s2_drain", 32'({bus.pht_resolve, bus.pht_index, bus.pht_incr, bus.pht_decr}), 32'({1'b1, 4'd12, 1'b0, 1'b1}));
    chk("s2_ghr", 32'(bus.ghr), 32'd0);

    // fill the queue while a prediction is held and pending
    step(1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
    chk("s3_ready_before_full", 32'(bus.res_ready), 32'd1);
    step(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("s3_full", 32'(bus.res_ready), 32'd0);
    chk("s3_wait_no_ack", 32'(bus.pred_ack), 32'd0);
    step(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("s3_preempt", 32'({bus.pht_resolve, bus.pred_ack, bus.pht_index}), 32'({1'b1, 1'b0, 4'd1}));
    step(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("s3_ack_after_drain", 32'(bus.pred_ack), 32'd1);
    step(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    idle();
    idle();
    idle();
    idle();
    chk("s3_ghr_1101", 32'(bus.ghr), 32'(4'b1101));

    // steer ghr to 0011, then gshare index and timeout
    step(1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    idle();
    step(1'b1, 4'b0110, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("s4_ghr_0011", 32'(bus.ghr), 32'(4'b0011));
    chk("s4_ack", 32'(bus.pred_ack), 32'd1);
    step(1'b1, 4'b0110, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("s4_index_0101", 32'(bus.pht_index), 32'(4'b0101));
    step(1'b1, 4'b0110, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0110, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0110, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("s4_no_early_timeout", 32'(bus.pred_out_valid), 32'd0);
    step(1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("s4_timeout", 32'({bus.pred_out_valid, bus.pred_timeout, bus.pred_out}), 32'({1'b1, 1'b1, 1'b0}));
    chk("s4_back_in_idle", 32'(bus.pred_ack), 32'd1);
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle();

    // reset while waiting with two queued resolves
    step(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.res_req = 1'b0;
    model_reset();
    #2;
    chk("s5_rst_ready", 32'(bus.res_ready), 32'd1);
    chk("s5_rst_strobes", 32'({bus.pht_predict, bus.pht_resolve, bus.pht_incr, bus.pht_decr}), 32'd0);
    chk("s5_rst_ghr", 32'(bus.ghr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("s5_quiet", 32'({bus.pred_out_valid, bus.pht_resolve, bus.pht_predict}), 32'd0);
    end

    // random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) < 40), W'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 55), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 25), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 12; i++) idle();
    chk("end_drain_queue_empty", 32'(q_drain.size()), 32'd0);
    chk("end_ack_queue_empty", 32'(q_ack.size()), 32'd0);
    chk("end_result_queue_empty", 32'(q_res.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
